// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and baud divisor helper for the UART echo block.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

   // Clocks per oversampling tick, integer-truncated.
   function automatic int baud_dvsr(input int sys_freq, input int sample, input int baud);
      return sys_freq / (sample * baud);
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous first-word-fall-through FIFO with wrap-around pointers.
// Ports: clk, reset_n (async active-low), push/wdata write side, pop/rdata read side,
//        empty/full flags (combinational from the word count).
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   // Push on full and pop on empty are dropped, so the count stays exact
   // even when both are requested together at a boundary.
   always_comb begin
      empty   = cnt_q == '0;
      full    = cnt_q == CW'(DEPTH);
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      wptr_d  = wptr_q + AW'(do_push);
      rptr_d  = rptr_q + AW'(do_pop);
      cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
      rdata   = mem_q[rptr_q];
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end

   always_ff @(posedge clk)
      if (do_push) mem_q[wptr_q] <= wdata;

endmodule

// File: rtl/uart_protocol.sv
// uart_protocol: UART receiver and transmitter with an RX->TX FIFO echo path.
// Ports: clk, reset_n (async active-low), rx serial in, tx serial out,
//        RX_status_register {overrun(sticky), full, empty},
//        TX_status_register {busy, full, empty}.
module uart_protocol
   import uart_pkg::*;
#(
   parameter int DATA_SIZE = 8,
   parameter int SIZE_FIFO = 8,
   parameter int SYS_FREQ  = 50000000,
   parameter int BAUD_RATE = 115200,
   parameter int SAMPLE    = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   output logic       tx,
   output logic [2:0] RX_status_register,
   output logic [2:0] TX_status_register
);

   localparam int BAUD_DVSR = baud_dvsr(SYS_FREQ, SAMPLE, BAUD_RATE);
   localparam int DW = $clog2(BAUD_DVSR + 1);
   localparam int CW = $clog2(SAMPLE + 1);
   localparam int BW = $clog2(DATA_SIZE + 1);

   logic [DW-1:0] baud_q, baud_d;
   logic          tick;
   logic [1:0]    rx_sync_q;
   logic          rx_s;

   uart_state_e          rx_state_q, rx_state_d, tx_state_q, tx_state_d;
   logic [CW-1:0]        rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]        rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
   logic [DATA_SIZE-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
   logic                 tx_q, tx_d;
   logic [2:0]           rx_stat_q, rx_stat_d, tx_stat_q, tx_stat_d;

   logic                 rx_push, rx_pop, rx_empty, rx_full;
   logic                 tx_push, tx_pop, tx_empty, tx_full;
   logic [DATA_SIZE-1:0] rx_rdata, tx_rdata;

   uart_fifo #(.WIDTH(DATA_SIZE), .DEPTH(SIZE_FIFO)) u_rx_fifo (
      .clk(clk), .reset_n(reset_n), .push(rx_push), .pop(rx_pop),
      .wdata(rx_shift_q), .rdata(rx_rdata), .empty(rx_empty), .full(rx_full));

   uart_fifo #(.WIDTH(DATA_SIZE), .DEPTH(SIZE_FIFO)) u_tx_fifo (
      .clk(clk), .reset_n(reset_n), .push(tx_push), .pop(tx_pop),
      .wdata(rx_rdata), .rdata(tx_rdata), .empty(tx_empty), .full(tx_full));

   always_comb begin
      tick   = baud_q == DW'(BAUD_DVSR - 1);
      baud_d = tick ? '0 : baud_q + 1'b1;
      rx_s   = rx_sync_q[1];
      rx_pop  = ~rx_empty & ~tx_full;
      tx_push = rx_pop;
   end

   // Receiver: start bit re-checked at its midpoint, then data and stop
   // bits sampled every SAMPLE ticks from there (mid-bit).
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_push    = 1'b0;
      case (rx_state_q)
         IDLE:
            if (!rx_s) begin
               rx_state_d = START;
               rx_cnt_d   = '0;
            end
         START:
            if (tick) begin
               if (rx_cnt_q == CW'(SAMPLE/2 - 1)) begin
                  rx_state_d = rx_s ? IDLE : DATA;
                  rx_cnt_d   = '0;
                  rx_bit_d   = '0;
               end else rx_cnt_d = rx_cnt_q + 1'b1;
            end
         DATA:
            if (tick) begin
               if (rx_cnt_q == CW'(SAMPLE - 1)) begin
                  rx_cnt_d   = '0;
                  rx_shift_d = {rx_s, rx_shift_q[DATA_SIZE-1:1]};
                  rx_state_d = rx_bit_q == BW'(DATA_SIZE - 1) ? STOP : DATA;
                  rx_bit_d   = rx_bit_q + 1'b1;
               end else rx_cnt_d = rx_cnt_q + 1'b1;
            end
         STOP:
            if (tick) begin
               if (rx_cnt_q == CW'(SAMPLE - 1)) begin
                  rx_state_d = IDLE;
                  rx_push    = rx_s;
               end else rx_cnt_d = rx_cnt_q + 1'b1;
            end
         default: rx_state_d = IDLE;
      endcase
   end

   // Transmitter: a waiting word is loaded at the end of the stop bit so
   // consecutive frames leave no idle gap.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         IDLE:
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_rdata;
               tx_cnt_d   = '0;
               tx_state_d = START;
            end
         START:
            if (tick) begin
               if (tx_cnt_q == CW'(SAMPLE - 1)) begin
                  tx_state_d = DATA;
                  tx_cnt_d   = '0;
                  tx_bit_d   = '0;
               end else tx_cnt_d = tx_cnt_q + 1'b1;
            end
         DATA:
            if (tick) begin
               if (tx_cnt_q == CW'(SAMPLE - 1)) begin
                  tx_cnt_d   = '0;
                  tx_shift_d = tx_shift_q >> 1;
                  tx_state_d = tx_bit_q == BW'(DATA_SIZE - 1) ? STOP : DATA;
                  tx_bit_d   = tx_bit_q + 1'b1;
               end else tx_cnt_d = tx_cnt_q + 1'b1;
            end
         STOP:
            if (tick) begin
               if (tx_cnt_q == CW'(SAMPLE - 1)) begin
                  tx_cnt_d   = '0;
                  tx_pop     = ~tx_empty;
                  tx_shift_d = tx_empty ? tx_shift_q : tx_rdata;
                  tx_state_d = tx_empty ? IDLE : START;
               end else tx_cnt_d = tx_cnt_q + 1'b1;
            end
         default: tx_state_d = IDLE;
      endcase
      tx_d = tx_state_d == START ? 1'b0 : tx_state_d == DATA ? tx_shift_d[0] : 1'b1;
   end

   always_comb begin
      rx_stat_d = {rx_stat_q[2] | (rx_push & rx_full), rx_full, rx_empty};
      tx_stat_d = {tx_state_q != IDLE, tx_full, tx_empty};
      tx                 = tx_q;
      RX_status_register = rx_stat_q;
      TX_status_register = tx_stat_q;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         baud_q     <= '0;
         rx_sync_q  <= 2'b11;
         rx_state_q <= IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         tx_state_q <= IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
         rx_stat_q  <= 3'b001;
         tx_stat_q  <= 3'b001;
      end else begin
         baud_q     <= baud_d;
         rx_sync_q  <= {rx_sync_q[0], rx};
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
         rx_stat_q  <= rx_stat_d;
         tx_stat_q  <= tx_stat_d;
      end

endmodule

// File: tb/tb_uart_protocol.sv
// tb_uart_protocol: directed self-checking bench for the UART echo block.
module tb_uart_protocol;

   localparam int BIT = 432;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx = 1'b1;
   logic       tx;
   logic [2:0] rx_stat, tx_stat;
   int         total = 0;
   int         bad = 0;
   logic [7:0] d1, d2;

   uart_protocol dut (
      .clk(clk), .reset_n(reset_n), .rx(rx), .tx(tx),
      .RX_status_register(rx_stat), .TX_status_register(tx_stat));

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic stop, input int stop_len);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (BIT) @(negedge clk);
      end
      rx = stop;
      repeat (stop_len) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (tx !== 1'b0 && n < 40 * BIT) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_seen"}, {31'd0, tx}, 32'd0);
   endtask

   task automatic capture(input string tag, output logic [7:0] d);
      d = '0;
      wait_start(tag);
      if (tx === 1'b0) begin
         repeat (BIT/2) @(negedge clk);
         chk({tag, "_start"}, {31'd0, tx}, 32'd0);
         chk({tag, "_busy"}, {31'd0, tx_stat[2]}, 32'd1);
         for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            d[i] = tx;
         end
         repeat (BIT) @(negedge clk);
         chk({tag, "_stop"}, {31'd0, tx}, 32'd1);
      end
   endtask

   task automatic quiet(input string tag, input int n);
      int lows = 0;
      repeat (n) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk(tag, lows, 0);
   endtask

   initial begin
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_rxstat", {29'd0, rx_stat}, 32'd1);
      chk("rst_txstat", {29'd0, tx_stat}, 32'd1);

      fork
         send(8'hCD, 1'b1, BIT);
         capture("f1", d1);
      join
      chk("f1_byte", {24'd0, d1}, 32'hCD);
      repeat (BIT) @(negedge clk);
      chk("f1_rxstat", {29'd0, rx_stat}, 32'd1);
      chk("f1_txstat", {29'd0, tx_stat}, 32'd1);

      fork
         begin
            send(8'hCD, 1'b1, BIT);
            repeat (5 * BIT) @(negedge clk);
            send(8'hCD, 1'b1, BIT);
         end
         begin
            capture("p1", d1);
            capture("p2", d2);
         end
      join
      chk("p1_byte", {24'd0, d1}, 32'hCD);
      chk("p2_byte", {24'd0, d2}, 32'hCD);
      chk("p_ovr", {31'd0, rx_stat[2]}, 32'd0);
      repeat (BIT) @(negedge clk);
      chk("p_txstat", {29'd0, tx_stat}, 32'd1);

      rx = 1'b0;
      repeat (100) @(negedge clk);
      rx = 1'b1;
      quiet("glitch_quiet", 15 * BIT);
      chk("glitch_rxstat", {29'd0, rx_stat}, 32'd1);

      // Stop bit held low past the receiver's mid-bit sample, released
      // before a new start bit could be confirmed.
      fork
         send(8'hCD, 1'b0, 300);
         quiet("ferr_quiet", 25 * BIT);
      join
      chk("ferr_rxstat", {29'd0, rx_stat}, 32'd1);
      chk("ferr_txstat", {29'd0, tx_stat}, 32'd1);

      fork
         send(8'hCD, 1'b1, BIT);
         begin
            wait_start("r");
            repeat (3 * BIT) @(negedge clk);
         end
      join
      chk("r_pre_busy", {31'd0, tx_stat[2]}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("r_tx", {31'd0, tx}, 32'd1);
      chk("r_txstat", {29'd0, tx_stat}, 32'd1);
      chk("r_rxstat", {29'd0, rx_stat}, 32'd1);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("r_post_txstat", {29'd0, tx_stat}, 32'd1);
      chk("r_post_rxstat", {29'd0, rx_stat}, 32'd1);
      quiet("r_quiet", 12 * BIT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_protocol.md
UART_PROTOCOL -- requirements
Module: uart_protocol

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8: data bits per frame.
REQ-002 SHALL have parameter SIZE_FIFO, default 8: depth in words of each FIFO; power of two.
REQ-003 SHALL have parameter SYS_FREQ, default 50000000: clk frequency in Hz.
REQ-004 SHALL have parameter BAUD_RATE, default 115200: line rate in bit/s.
REQ-005 SHALL have parameter SAMPLE, default 16: oversampling ticks per bit.
REQ-006 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port rx, input, 1 bit: serial receive line, idle high.
REQ-009 SHALL have port tx, output, 1 bit: serial transmit line, idle high.
REQ-010 SHALL have port RX_status_register, output, 3 bits: [0] RX FIFO empty, [1] RX FIFO full, [2] RX overrun (sticky).
REQ-011 SHALL have port TX_status_register, output, 3 bits: [0] TX FIFO empty, [1] TX FIFO full, [2] transmitter busy.

Function
REQ-012 SHALL derive BAUD_DVSR = SYS_FREQ/(SAMPLE*BAUD_RATE), integer-truncated (27 at defaults); a one-cycle tick SHALL pulse every BAUD_DVSR clocks.
REQ-013 SHALL pass rx through a 2-flop synchronizer before use.
REQ-014 RX FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE->START on synchronized rx = 0.
REQ-015 In START, after SAMPLE/2 ticks with rx still 0, the FSM SHALL go to DATA.
- If rx = 1 at that point, it SHALL return to IDLE (glitch rejected).
REQ-016 In DATA, the FSM SHALL sample one bit every SAMPLE ticks, LSB first, DATA_SIZE bits, then go to STOP.
REQ-017 In STOP, after SAMPLE ticks, the FSM SHALL return to IDLE.
- Stop bit = 1: push byte into RX FIFO.
- Stop bit = 0: frame error; byte discarded.
REQ-018 Push when RX FIFO full SHALL drop the byte and set RX_status_register[2] until reset.
REQ-019 Echo path: when RX FIFO not empty and TX FIFO not full, one word SHALL move RX FIFO -> TX FIFO per clock.
REQ-020 TX FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE->START when TX FIFO not empty; pop that word.
- Send 0 for SAMPLE ticks.
- Send DATA_SIZE bits LSB first, SAMPLE ticks each.
- Send 1 for SAMPLE ticks, then IDLE.
- Back-to-back words SHALL be sent with no idle gap.
REQ-021 TX_status_register[2] SHALL be 1 in all TX states except IDLE.
REQ-022 FIFOs SHALL be synchronous, first-word-fall-through, with wrap-around pointers.
- Simultaneous push and pop on a full or empty FIFO SHALL keep the count correct.
- Pop when empty and push when full SHALL be ignored.
REQ-023 Status bits SHALL be registered and reflect FIFO state with one-cycle latency.

Reset
REQ-024 reset_n = 0 SHALL asynchronously clear both FSMs to IDLE, clear FIFO pointers and counts, set tx = 1, set RX_status_register = 3'b001 and TX_status_register = 3'b001.
REQ-025 Reset asserted mid-frame SHALL abort the frame; the partial byte SHALL be discarded.

Structure
REQ-026 FSM state encodings and the BAUD_DVSR computation SHALL live in a shared package uart_pkg.
REQ-027 The FIFO SHALL be one sub-module, uart_fifo, instantiated twice.
- Baud generator, RX FSM, TX FSM and echo logic SHALL be inline.

Verification
REQ-028 After reset: tx = 1, RX_status_register = 3'b001, TX_status_register = 3'b001.
REQ-029 Drive frame 0xCD (bits 1,0,1,1,0,0,1,1 LSB first) at 432 clocks/bit -> within 2 bit-times of stop, tx emits start, bits of 0xCD, stop; status returns to 3'b001.
REQ-030 Two 0xCD frames spaced 5 bit-times -> two identical echoed frames on tx; RX_status_register[2] = 0.
REQ-031 rx low pulse of 100 clocks -> no frame received, tx stays 1.
REQ-032 Frame with stop bit = 0 -> byte discarded, no tx activity.
REQ-033 Reset mid-transmit -> tx = 1 immediately; FIFOs empty.
